asic_seq_ctrl: RTL and testbench
================================

Name: asic_seq_ctrl

Overview:
- Sequences one inference on the transformer core `Top`.
- Streams the staged input buffer (ifmap, weight, bias) into the core and collects its ofmap results into the result buffer.
- In two-pass mode, writes the first-pass results back into the bias region and re-streams the buffer.
- Sits between the AXI/MMIO slave (start, mode, interrupt) and the core/SRAM buffers.

Parameters:
- IN_WORDS, 1104, words streamed per pass (16 ifmap + 1024 weight + 64 bias)
- BIAS_BASE, 1040, input-buffer word address of the first bias word
- BIAS_WORDS, 64, results written back in pass 1 of mode 1
- OUT_WORDS, 64, results delivered to the result buffer per job
- ADDR_W, 11, input-buffer address width
- DW, 32, data width
- TIMEOUT, 4096, idle cycles without core_valid before aborting with error

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous, active-low reset
- start  in  1  single-cycle job request from MMIO
- mode  in  1  0 = single pass; 1 = bias pass then ofmap pass (sampled at start)
- abort  in  1  cancel job
- buf_re  out  1  input-buffer read enable
- buf_raddr  out  ADDR_W  input-buffer read address
- buf_rdata  in  DW  read data, valid 1 cycle after buf_re
- buf_we  out  1  input-buffer write enable (bias write-back)
- buf_waddr  out  ADDR_W  write address
- buf_wdata  out  DW  write data
- core_start  out  1  pulse aligned with the first word of a pass (core `ready`)
- core_data  out  DW  stream word to the core
- core_valid  in  1  core result strobe
- core_ofmap  in  DW  core result
- res_we  out  1  result-buffer write
- res_addr  out  6  result index 0..OUT_WORDS-1
- res_wdata  out  DW  result data
- busy  out  1  job in progress
- irq  out  1  level interrupt, held until irq_clr
- irq_clr  in  1  clear irq/err
- err  out  1  timeout flag, qualifies irq

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE.
- States: IDLE, STREAM, COLLECT, DONE.
- IDLE:
  - start latches mode and clears rd_ptr, str_cnt, res_cnt and pass.
  - Next state STREAM, busy=1.
  - start while busy is ignored.
- STREAM:
  - buf_re=1, buf_raddr=rd_ptr every cycle; rd_ptr increments 0..IN_WORDS-1, no gaps.
  - core_data is registered from buf_rdata.
  - core_start pulses on the cycle core_data = word 0.
  - Latency: start at cycle T → word 0 on core_data at T+2; word IN_WORDS-1 at T+IN_WORDS+1.
  - After the last word is presented, go to COLLECT.
- Result handling (STREAM and COLLECT): each core_valid increments res_cnt.
  - Bias write-back, only while mode=1 and pass=0: buf_we=1, buf_waddr=BIAS_BASE+res_cnt, buf_wdata=core_ofmap.
  - Otherwise: res_we=1, res_addr=res_cnt, res_wdata=core_ofmap.
  - All writes are combinational in the same cycle as core_valid.
- Pass 1 of mode 1 completes when res_cnt reaches BIAS_WORDS; on that event:
  - res_cnt=0, pass=1, rd_ptr=0; the next state is STREAM, and that stream carries the updated bias.
  - If this happens while the first stream is still running, the current stream finishes first, then re-enters STREAM.
- Job complete when the final pass has received OUT_WORDS results and its stream has ended.
  - Enter DONE with irq=1, busy=0.
  - Extra core_valid beyond the count is ignored (no write).
- Watchdog: counter clears on each core_valid and on each state entry, and runs in COLLECT only.
  - Reaching TIMEOUT → DONE with err=1, irq=1.
- DONE: holds irq until irq_clr, then IDLE.
  - irq_clr is ignored in other states.
  - start in DONE is ignored until irq_clr.
- abort in STREAM/COLLECT: next cycle IDLE, busy=0, no irq. Already-written results are kept and core_start is not reissued.
- abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- Read/write to the same buffer address in one cycle: the buffer returns old data (read-first).
- Reset mid-job: immediate return to reset values. Buffer contents are not this block's concern.

Decomposition:
- Package asic_seq_pkg holds:
  - the state_t enum (IDLE, STREAM, COLLECT, DONE);
  - the default constants IN_WORDS/BIAS_BASE/BIAS_WORDS/OUT_WORDS.
- One natural sub-module, asic_seq_watchdog: the timeout counter with clear/enable and an expired flag.
- The rest of the block stays flat.

Test Plan:
- Mode 0, buffer word i = i, core model returns 64 results 100 cycles after the stream:
  - core_start at T+2 with core_data=0; core_data=1103 at T+1105.
  - res_addr 0..63 are written; irq=1, err=0; buf_we never asserted.
- Mode 1, pass 1 results = 0xB000+i:
  - buf_we writes 0xB000..0xB03F to addresses 1040..1103.
  - The second stream shows core_data=0xB000 at stream offset 1040.
  - 64 results go to res_addr 0..63, then irq.
- Core never asserts core_valid: DONE after TIMEOUT cycles in COLLECT, irq=1, err=1. irq_clr → IDLE, err=0.
- abort at stream word 500: next cycle busy=0, state IDLE, irq=0. A following start restarts at word 0.
- Control-input corner cases:
  - start pulsed while busy → no restart.
  - start and abort together in IDLE → stays IDLE.
  - 70 core_valid in mode 0 → only 64 res_we.
- ARESETn low mid-STREAM for 1 cycle → all outputs 0 next cycle; a new start then completes normally.

Source files
------------

// File: rtl/asic_seq_ctrl_pkg.sv
// Shared types and default geometry for the inference sequencer.
package asic_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      COLLECT = 2'd2,
      DONE    = 2'd3
   } state_t;

   // 16 ifmap + 1024 weight + 64 bias words per pass
   localparam int unsigned IN_WORDS   = 1104;
   localparam int unsigned BIAS_BASE  = 1040;
   localparam int unsigned BIAS_WORDS = 64;
   localparam int unsigned OUT_WORDS  = 64;
   localparam int unsigned ADDR_W     = 11;
   localparam int unsigned DW         = 32;
   localparam int unsigned TIMEOUT    = 4096;

endpackage

// File: rtl/asic_seq_ctrl_if.sv
// Buffer, core-stream and result-buffer signals between the sequencer and its datapath.
interface asic_seq_ctrl_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DW     = 32
);
   logic              buf_re;
   logic [ADDR_W-1:0] buf_raddr;
   logic [DW-1:0]     buf_rdata;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_waddr;
   logic [DW-1:0]     buf_wdata;
   logic              core_start;
   logic [DW-1:0]     core_data;
   logic              core_valid;
   logic [DW-1:0]     core_ofmap;
   logic              res_we;
   logic [5:0]        res_addr;
   logic [DW-1:0]     res_wdata;

   modport master (
      output buf_re, buf_raddr, buf_we, buf_waddr, buf_wdata,
      output core_start, core_data, res_we, res_addr, res_wdata,
      input  buf_rdata, core_valid, core_ofmap
   );

   modport slave (
      input  buf_re, buf_raddr, buf_we, buf_waddr, buf_wdata,
      input  core_start, core_data, res_we, res_addr, res_wdata,
      output buf_rdata, core_valid, core_ofmap
   );
endinterface

// File: rtl/asic_seq_ctrl_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear, flags TIMEOUT.
module asic_seq_watchdog #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic ACLK,
   input  logic ARESETn,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge ACLK) begin
      if (!ARESETn || clr) begin
         cnt <= '0;
      end else if (en && (cnt != CW'(TIMEOUT - 1))) begin
         cnt <= cnt + CW'(1);
      end
   end

   // flags the TIMEOUT-th enabled cycle; the caller masks a same-cycle clear
   always_comb expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/asic_seq_ctrl.sv
// Inference sequencer: streams the input buffer into the core and routes its results,
// with an optional bias write-back pass.
import asic_seq_pkg::*;

module asic_seq_ctrl #(
   parameter int unsigned IN_WORDS   = asic_seq_pkg::IN_WORDS,
   parameter int unsigned BIAS_BASE  = asic_seq_pkg::BIAS_BASE,
   parameter int unsigned BIAS_WORDS = asic_seq_pkg::BIAS_WORDS,
   parameter int unsigned OUT_WORDS  = asic_seq_pkg::OUT_WORDS,
   parameter int unsigned ADDR_W     = asic_seq_pkg::ADDR_W,
   parameter int unsigned DW         = asic_seq_pkg::DW,
   parameter int unsigned TIMEOUT    = asic_seq_pkg::TIMEOUT
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic               start,
   input  logic               mode,
   input  logic               abort,
   asic_seq_ctrl_if.master    bus,
   output logic               busy,
   output logic               irq,
   input  logic               irq_clr,
   output logic               err
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr, str_cnt;
   logic [6:0]        res_cnt, res_lim;
   logic              mode_q, pass_q, restream_q, data_vld;
   logic              irq_q, err_q;

   logic active, wb_pass, accept, bias_evt, res_full, stream_end, restream;
   logic start_job, new_stream, timeout;
   logic wd_clr, wd_en, wd_expired;

   always_comb begin
      active     = (state_q == STREAM) || (state_q == COLLECT);
      wb_pass    = mode_q && !pass_q;
      res_lim    = wb_pass ? 7'(BIAS_WORDS) : 7'(OUT_WORDS);
      accept     = active && bus.core_valid && (res_cnt < res_lim);
      bias_evt   = accept && wb_pass && (res_cnt == res_lim - 7'd1);
      res_full   = !wb_pass && (res_cnt == 7'(OUT_WORDS));
      stream_end = (state_q == STREAM) && data_vld && (str_cnt == ADDR_W'(IN_WORDS - 1));
      restream   = restream_q || bias_evt;
      timeout    = wd_expired && !bus.core_valid;
      start_job  = (state_q == IDLE) && start && !abort;
   end

   always_comb begin
      state_d    = state_q;
      new_stream = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_job) begin
               state_d    = STREAM;
               new_stream = 1'b1;
            end
         end
         STREAM: begin
            if (abort) begin
               state_d = IDLE;
            end else if (stream_end) begin
               // a bias pass finished mid-stream: re-stream straight after this one
               state_d    = restream ? STREAM : COLLECT;
               new_stream = restream;
            end
         end
         COLLECT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (bias_evt) begin
               state_d    = STREAM;
               new_stream = 1'b1;
            end else if (res_full || timeout) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (irq_clr) state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      wd_clr = bus.core_valid || (state_d != state_q);
      wd_en  = (state_q == COLLECT);
   end

   asic_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q    <= IDLE;
         rd_ptr     <= '0;
         str_cnt    <= '0;
         res_cnt    <= '0;
         mode_q     <= 1'b0;
         pass_q     <= 1'b0;
         restream_q <= 1'b0;
         data_vld   <= 1'b0;
         irq_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_vld <= bus.buf_re && !abort;

         if (new_stream) begin
            rd_ptr  <= '0;
            str_cnt <= '0;
         end else begin
            if (bus.buf_re) rd_ptr <= rd_ptr + ADDR_W'(1);
            if ((state_q == STREAM) && data_vld) str_cnt <= str_cnt + ADDR_W'(1);
         end

         if (start_job) begin
            mode_q  <= mode;
            pass_q  <= 1'b0;
            res_cnt <= '0;
         end else if (bias_evt) begin
            pass_q  <= 1'b1;
            res_cnt <= '0;
         end else if (accept) begin
            res_cnt <= res_cnt + 7'd1;
         end

         if (new_stream || (state_d == IDLE)) begin
            restream_q <= 1'b0;
         end else if (bias_evt) begin
            restream_q <= 1'b1;
         end

         if ((state_q != DONE) && (state_d == DONE)) begin
            irq_q <= 1'b1;
            err_q <= !res_full;
         end else if ((state_q == DONE) && irq_clr) begin
            irq_q <= 1'b0;
            err_q <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.buf_re     = (state_q == STREAM) && (rd_ptr != ADDR_W'(IN_WORDS));
      bus.buf_raddr  = bus.buf_re ? rd_ptr : '0;
      bus.core_data  = data_vld ? bus.buf_rdata : '0;
      bus.core_start = data_vld && (state_q == STREAM) && (str_cnt == '0);

      bus.buf_we     = accept && wb_pass;
      bus.buf_waddr  = bus.buf_we ? (ADDR_W'(BIAS_BASE) + ADDR_W'(res_cnt)) : '0;
      bus.buf_wdata  = bus.buf_we ? bus.core_ofmap : '0;

      bus.res_we     = accept && !wb_pass;
      bus.res_addr   = bus.res_we ? res_cnt[5:0] : '0;
      bus.res_wdata  = bus.res_we ? bus.core_ofmap : '0;

      busy = active;
      irq  = irq_q;
      err  = err_q;
   end

endmodule

// File: tb/tb_asic_seq_ctrl.sv
// Directed bench for asic_seq_ctrl: buffer model plus hand-driven core results.
module tb_asic_seq_ctrl;
   import asic_seq_pkg::*;

   logic ACLK, ARESETn, start, mode, abort, irq_clr;
   logic busy, irq, err;
   logic preload;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_res = 0;

   logic [31:0] mem     [0:IN_WORDS-1];
   logic [31:0] exp_mem [0:IN_WORDS-1];

   asic_seq_ctrl_if #(.ADDR_W(ADDR_W), .DW(DW)) bus ();

   asic_seq_ctrl dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .start   (start),
      .mode    (mode),
      .abort   (abort),
      .bus     (bus),
      .busy    (busy),
      .irq     (irq),
      .irq_clr (irq_clr),
      .err     (err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // synchronous read-first buffer
   always @(posedge ACLK) begin
      if (preload) begin
         for (int i = 0; i < int'(IN_WORDS); i++) mem[i] <= 32'(i);
         bus.buf_rdata <= '0;
      end else begin
         if (bus.buf_re) bus.buf_rdata <= mem[bus.buf_raddr];
         if (bus.buf_we) mem[bus.buf_waddr] <= bus.buf_wdata;
      end
   end

   task automatic tick();
      @(negedge ACLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic do_start(input logic m);
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      mode  = 1'b0;
   endtask

   task automatic stream_check(input int unsigned nwords);
      int unsigned lat = 0;
      tick();
      while (bus.core_start !== 1'b1 && lat < 8) begin
         tick();
         lat++;
      end
      chk("core_start_latency", lat, 0);
      chk("core_start", 32'(bus.core_start), 1);
      for (int unsigned i = 0; i < nwords; i++) begin
         if (i != 0) tick();
         chk("core_data", bus.core_data, exp_mem[i]);
         if (i == 1) chk("core_start_single", 32'(bus.core_start), 0);
      end
      if (nwords == IN_WORDS) begin
         tick();
         chk("stream_tail_re", 32'(bus.buf_re), 0);
         chk("stream_tail_data", bus.core_data, 0);
      end
   endtask

   task automatic core_res(input logic [31:0] d, input logic exp_res, input logic exp_buf,
                           input int unsigned idx);
      bus.core_valid = 1'b1;
      bus.core_ofmap = d;
      #1;
      if (bus.res_we === 1'b1) n_res++;
      chk("res_we", 32'(bus.res_we), 32'(exp_res));
      chk("buf_we", 32'(bus.buf_we), 32'(exp_buf));
      if (exp_res) begin
         chk("res_addr", 32'(bus.res_addr), idx);
         chk("res_wdata", bus.res_wdata, d);
      end
      if (exp_buf) begin
         chk("buf_waddr", 32'(bus.buf_waddr), BIAS_BASE + idx);
         chk("buf_wdata", bus.buf_wdata, d);
      end
      @(negedge ACLK);
      bus.core_valid = 1'b0;
      bus.core_ofmap = '0;
   endtask

   task automatic idle_cycles(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   initial begin
      int unsigned k;
      ARESETn = 1'b0; preload = 1'b1;
      start = 1'b0; mode = 1'b0; abort = 1'b0; irq_clr = 1'b0;
      bus.core_valid = 1'b0; bus.core_ofmap = '0;
      for (int i = 0; i < int'(IN_WORDS); i++) exp_mem[i] = 32'(i);
      tick(); tick();
      preload = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_buf_re", 32'(bus.buf_re), 0);
      chk("rst_core_start", 32'(bus.core_start), 0);
      chk("rst_core_data", bus.core_data, 0);
      ARESETn = 1'b1;
      tick();

      // mode 0: single pass, 70 results of which 64 are accepted
      do_start(1'b0);
      chk("m0_busy", 32'(busy), 1);
      chk("m0_raddr0", 32'(bus.buf_raddr), 0);
      chk("m0_re0", 32'(bus.buf_re), 1);
      stream_check(IN_WORDS);
      idle_cycles(50);
      start = 1'b1; tick(); start = 1'b0;
      chk("busy_start_ignored_re", 32'(bus.buf_re), 0);
      chk("busy_start_ignored_busy", 32'(busy), 1);
      idle_cycles(49);
      n_res = 0;
      for (int unsigned i = 0; i < 70; i++)
         core_res(32'hA000 + i, (i < 64) ? 1'b1 : 1'b0, 1'b0, i);
      chk("m0_res_total", n_res, 64);
      chk("m0_irq", 32'(irq), 1);
      chk("m0_err", 32'(err), 0);
      chk("m0_busy_done", 32'(busy), 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("done_start_ignored", 32'(busy), 0);
      chk("done_irq_held", 32'(irq), 1);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("m0_irq_clr", 32'(irq), 0);

      // mode 1: bias pass writes back, second stream carries it
      do_start(1'b1);
      stream_check(IN_WORDS);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("irq_clr_ignored_busy", 32'(busy), 1);
      idle_cycles(99);
      for (int unsigned i = 0; i < BIAS_WORDS; i++) begin
         core_res(32'hB000 + i, 1'b0, 1'b1, i);
         exp_mem[BIAS_BASE + i] = 32'hB000 + i;
      end
      chk("m1_restream_re", 32'(bus.buf_re), 1);
      chk("m1_restream_raddr", 32'(bus.buf_raddr), 0);
      stream_check(IN_WORDS);
      idle_cycles(100);
      for (int unsigned i = 0; i < OUT_WORDS; i++) core_res(32'hC000 + i, 1'b1, 1'b0, i);
      tick();
      chk("m1_irq", 32'(irq), 1);
      chk("m1_err", 32'(err), 0);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;

      // core silent: watchdog expires TIMEOUT cycles into COLLECT
      do_start(1'b0);
      k = 0;
      while (irq !== 1'b1 && k < 8000) begin
         tick();
         k++;
      end
      chk("to_cycles", k, IN_WORDS + TIMEOUT + 1);
      chk("to_irq", 32'(irq), 1);
      chk("to_err", 32'(err), 1);
      chk("to_busy", 32'(busy), 0);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      chk("to_clr_irq", 32'(irq), 0);
      chk("to_clr_err", 32'(err), 0);

      // abort at stream word 500
      do_start(1'b0);
      idle_cycles(501);
      chk("ab_word500", bus.core_data, exp_mem[500]);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_busy", 32'(busy), 0);
      chk("ab_irq", 32'(irq), 0);
      chk("ab_re", 32'(bus.buf_re), 0);
      chk("ab_core_data", bus.core_data, 0);
      idle_cycles(3);
      chk("ab_no_core_start", 32'(bus.core_start), 0);

      // start and abort together in IDLE
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("sa_busy", 32'(busy), 0);
      chk("sa_re", 32'(bus.buf_re), 0);

      // restart after abort, then reset mid-stream
      do_start(1'b0);
      stream_check(300);
      ARESETn = 1'b0; tick(); ARESETn = 1'b1;
      chk("mr_busy", 32'(busy), 0);
      chk("mr_re", 32'(bus.buf_re), 0);
      chk("mr_raddr", 32'(bus.buf_raddr), 0);
      chk("mr_core_data", bus.core_data, 0);
      chk("mr_core_start", 32'(bus.core_start), 0);
      chk("mr_irq", 32'(irq), 0);

      do_start(1'b0);
      stream_check(IN_WORDS);
      idle_cycles(100);
      for (int unsigned i = 0; i < OUT_WORDS; i++) core_res(32'hD000 + i, 1'b1, 1'b0, i);
      tick();
      chk("post_rst_irq", 32'(irq), 1);
      chk("post_rst_err", 32'(err), 0);
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
